// File: rtl/sysmem_ctrl.sv
// Bridges the picorv32 native bus onto four byte-lane BRAMs (1-cycle read latency)
// and provides a byte-serial loader that fills the RAM while the CPU is stalled.
module sysmem_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_valid,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  input  logic          ld_en,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic [AW+1:0] ld_count,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_ce,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, LOAD} state_t;
  state_t state, state_nx;

  logic [31:0] offset;
  logic        in_range;
  logic        cpu_go;
  logic        rsp_now;

  assign offset   = mem_addr - BASE_ADDR;
  assign in_range = (offset[31:AW+2] == '0);
  assign cpu_go   = (state == IDLE) && !ld_en && mem_valid;
  // Writes and out-of-range accesses complete without waiting on the RAM.
  assign rsp_now  = cpu_go && !(in_range && (mem_wstrb == 4'h0));
  assign ld_ready = resetn && (state == LOAD);

  always_comb begin
    state_nx = state;
    ram_ce   = '0;
    ram_we   = '0;
    ram_addr = '0;
    ram_di   = '0;
    unique case (state)
      IDLE: begin
        if (ld_en) begin
          state_nx = LOAD;
        end else if (mem_valid) begin
          state_nx = RESP;
          if (in_range) begin
            ram_addr = offset[AW+1:2];
            if (mem_wstrb == 4'h0) begin
              ram_ce   = 4'hF;
              state_nx = RD_WAIT;
            end else begin
              ram_ce = mem_wstrb;
              ram_we = mem_wstrb;
              ram_di = mem_wdata;
            end
          end
        end
      end
      RD_WAIT: state_nx = RESP;
      RESP:    state_nx = IDLE;
      LOAD: begin
        if (ld_valid) begin
          ram_addr = ld_count[AW+1:2];
          ram_ce   = 4'(1) << ld_count[1:0];
          ram_we   = 4'(1) << ld_count[1:0];
          ram_di   = {NUM_LANES{ld_data}};
        end
        if (!ld_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Keep the RAMs quiet while reset is asserted, whatever the bus is doing.
    if (!resetn) begin
      ram_ce = '0;
      ram_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ld_count  <= '0;
    end else begin
      state     <= state_nx;
      mem_ready <= rsp_now || (state == RD_WAIT);
      if (cpu_go && !in_range) mem_rdata <= '0;
      if (state == RD_WAIT) mem_rdata <= ram_do;
      if ((state == IDLE) && ld_en) ld_count <= '0;
      if ((state == LOAD) && ld_valid) ld_count <= ld_count + (AW+2)'(1);
    end
  end
endmodule

// File: tb/tb_sysmem_ctrl.sv
// Randomized bench for sysmem_ctrl: a byte-array reference memory predicts read data,
// latency and lane strobes; a four-lane BRAM model answers the controller's strobes.
module tb_sysmem_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ld_en, ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [11:0] ld_count;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_ce, ram_we;
  logic [31:0] ram_di, ram_do;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bram [4][1024];
  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  sysmem_ctrl dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_count(ld_count),
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (ram_ce[i]) begin
        if (ram_we[i]) bram[i][ram_addr] <= ram_di[8*i +: 8];
        else           ram_do[8*i +: 8]  <= bram[i][ram_addr];
      end

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h1000;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int b;
    if (!in_rng(a)) return 32'h0;
    b = int'(a & 32'hFFC);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int b;
    if (!in_rng(a)) return;
    b = int'(a & 32'hFFC);
    for (int i = 0; i < 4; i++) if (ws[i]) ref_mem[b+i] = wd[8*i +: 8];
  endfunction

  // One CPU transaction; returns the strobes seen in the issue cycle and the latency.
  task automatic cpu_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rd, output int lat,
                         output logic [3:0] ce, output logic [3:0] we, output logic [9:0] ra);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    #1;
    ce = ram_ce; we = ram_we; ra = ram_addr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 8);
    rd = mem_rdata;
    if (!mem_ready) lat = 99;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic test_reset;
    int n;
    resetn = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    ld_en = 1'b0; ld_valid = 1'b0; ld_data = 8'h0;
    repeat (3) begin
      @(negedge clk);
      vectors += 4;
      if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", mem_ready); end
      if (ram_ce !== 4'h0) begin miscompares++; $display("FAIL reset_ce got %h want 0", ram_ce); end
      if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
      if (mem_rdata !== 32'h0 || ld_count !== 12'h0) begin
        miscompares++; $display("FAIL reset_regs rdata %h count %0d want 0 0", mem_rdata, ld_count);
      end
    end
    resetn = 1'b1;
    #1;
    vectors++;
    if (ram_ce !== 4'hF) begin miscompares++; $display("FAIL release_ce got %h want f", ram_ce); end
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_ready && n < 8);
    vectors++;
    if (n != 2) begin miscompares++; $display("FAIL release_latency got %0d want 2", n); end
    mem_valid = 1'b0;
    // Reset while the read is waiting on the RAM must swallow the response.
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h0;
    @(negedge clk); resetn = 1'b0; mem_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", mem_ready); end
    end
    resetn = 1'b1;
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ra;
    @(negedge clk); ld_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4097; i++) begin
      ld_valid = 1'b1; ld_data = 8'($urandom);
      ref_mem[i % 4096] = ld_data;
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (ld_count !== 12'd1) begin miscompares++; $display("FAIL wrap_count got %0d want 1", ld_count); end
    if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_exit_ready got %b want 0", ld_ready); end
    cpu_txn(32'h0, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors++;
    if (rd !== exp_rd(32'h0)) begin miscompares++; $display("FAIL wrap_word0 got %h want %h", rd, exp_rd(32'h0)); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ra;
    cpu_txn(32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ce, we, ra);
    ref_wr(32'h10, 32'hDEADBEEF, 4'hF);
    vectors += 2;
    if (ce !== 4'hF || we !== 4'hF || ra !== 10'd4) begin
      miscompares++; $display("FAIL wr_strobes ce %h we %h addr %0d want f f 4", ce, we, ra);
    end
    if (lat != 1) begin miscompares++; $display("FAIL wr_latency got %0d want 1", lat); end
    cpu_txn(32'h10, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors += 2;
    if (lat != 2) begin miscompares++; $display("FAIL rd_latency got %0d want 2", lat); end
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", rd); end
  endtask

  task automatic test_partial;
    logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ra;
    cpu_txn(32'h10, 32'h00AA0000, 4'b0100, rd, lat, ce, we, ra);
    ref_wr(32'h10, 32'h00AA0000, 4'b0100);
    vectors++;
    if (ce !== 4'b0100 || we !== 4'b0100) begin
      miscompares++; $display("FAIL partial_strobes ce %h we %h want 4 4", ce, we);
    end
    cpu_txn(32'h12, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors++;
    if (rd !== 32'hDEAABEEF) begin miscompares++; $display("FAIL partial_data got %h want deaabeef", rd); end
  endtask

  task automatic test_oor;
    logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ra;
    cpu_txn(32'h1000, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors += 3;
    if (ce !== 4'h0) begin miscompares++; $display("FAIL oor_rd_ce got %h want 0", ce); end
    if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_rd_data got %h want 0", rd); end
    if (lat != 1) begin miscompares++; $display("FAIL oor_rd_latency got %0d want 1", lat); end
    cpu_txn(32'h2000, 32'h12345678, 4'hF, rd, lat, ce, we, ra);
    vectors++;
    if (ce !== 4'h0 || lat != 1) begin miscompares++; $display("FAIL oor_wr ce %h lat %0d want 0 1", ce, lat); end
  endtask

  task automatic test_loader;
    logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ra;
    logic [7:0] bytes [4];
    bytes[0] = 8'h13; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h00;
    @(negedge clk); ld_en = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h55AA55AA; mem_wstrb = 4'hF;
    vectors++;
    if (ld_ready !== 1'b1 || ld_count !== 12'd0) begin
      miscompares++; $display("FAIL ld_entry ready %b count %0d want 1 0", ld_ready, ld_count);
    end
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_data = bytes[k];
      ref_mem[k] = bytes[k];
      #1;
      vectors += 2;
      if (ram_ce !== 4'(1 << k) || ram_we !== 4'(1 << k) || ram_addr !== 10'd0 || ram_di !== {4{bytes[k]}}) begin
        miscompares++;
        $display("FAIL ld_strobe%0d ce %h we %h addr %0d di %h want %h %h 0 %h", k, ram_ce, ram_we, ram_addr,
                 ram_di, 4'(1 << k), 4'(1 << k), {4{bytes[k]}});
      end
      if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL ld_cpu_stall got %b want 0", mem_ready); end
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_en = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    vectors++;
    if (ld_count !== 12'd4 || ld_ready !== 1'b0) begin
      miscompares++; $display("FAIL ld_exit count %0d ready %b want 4 0", ld_count, ld_ready);
    end
    ld_valid = 1'b1; ld_data = 8'hEE;
    #1;
    vectors++;
    if (ram_ce !== 4'h0) begin miscompares++; $display("FAIL ld_stray_ce got %h want 0", ram_ce); end
    @(negedge clk); ld_valid = 1'b0;
    vectors++;
    if (ld_count !== 12'd4) begin miscompares++; $display("FAIL ld_hold got %0d want 4", ld_count); end
    cpu_txn(32'h0, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors++;
    if (rd !== 32'h00000013) begin miscompares++; $display("FAIL ld_readback got %h want 00000013", rd); end
    cpu_txn(32'h20, 32'h0, 4'h0, rd, lat, ce, we, ra);
    vectors++;
    if (rd !== exp_rd(32'h20)) begin miscompares++; $display("FAIL ld_cpu_ignored got %h want %h", rd, exp_rd(32'h20)); end
  endtask

  task automatic test_priority;
    int n;
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    @(negedge clk); ld_en = 1'b1;
    vectors++;
    if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL prio_early_ready got %b want 0", mem_ready); end
    @(negedge clk);
    vectors += 2;
    if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL prio_ready got %b want 1", mem_ready); end
    if (mem_rdata !== exp_rd(32'h10)) begin miscompares++; $display("FAIL prio_data got %h want %h", mem_rdata, exp_rd(32'h10)); end
    mem_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld_ready && n < 6);
    vectors += 2;
    if (n != 2) begin miscompares++; $display("FAIL prio_load_entry got %0d cycles want 2", n); end
    if (ld_count !== 12'd0) begin miscompares++; $display("FAIL prio_count got %0d want 0", ld_count); end
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd; logic [3:0] ws, ce, we; logic [9:0] ra; int lat;
    logic [3:0] exp_ce;
    for (int it = 0; it < 200; it++) begin
      a  = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 4095)) : ($urandom() | 32'h1000);
      wd = $urandom();
      ws = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ld_valid = 1'($urandom); ld_data = 8'($urandom);
      exp_ce = !in_rng(a) ? 4'h0 : (ws == 4'h0) ? 4'hF : ws;
      cpu_txn(a, wd, ws, rd, lat, ce, we, ra);
      ld_valid = 1'b0;
      vectors += 2;
      if (ce !== exp_ce || we !== (in_rng(a) ? ws : 4'h0)) begin
        miscompares++; $display("FAIL rnd%0d_strobes a %h ce %h we %h want %h", it, a, ce, we, exp_ce);
      end
      if (lat != ((in_rng(a) && ws == 4'h0) ? 2 : 1)) begin
        miscompares++; $display("FAIL rnd%0d_latency a %h ws %h got %0d", it, a, ws, lat);
      end
      if (in_rng(a)) begin
        vectors++;
        if (ra !== a[11:2]) begin miscompares++; $display("FAIL rnd%0d_addr got %0d want %0d", it, ra, a[11:2]); end
      end
      if (ws == 4'h0) begin
        vectors++;
        if (rd !== exp_rd(a)) begin miscompares++; $display("FAIL rnd%0d_data a %h got %h want %h", it, a, rd, exp_rd(a)); end
      end
      ref_wr(a, wd, ws);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_write_read();
    test_partial();
    test_oor();
    test_loader();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
